// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection for the 5-stage pipeline.
//
// Keeps a shadow copy of the E/M/W destination info, advanced in lock-step
// with the datapath pipeline registers. From that state and the decode-stage
// fields it produces the execute-stage operand forwarding selects, the
// fetch/decode stall, the decode/execute flush and a saturating count of
// stalled cycles.
//
// Build option: HAZARD_FORWARD_EN
//   defined   - M/W results are forwarded into execute; only a load followed
//               by a dependent instruction stalls (one cycle).
//   undefined - no forwarding (selects stay 00); a decode instruction stalls
//               while an E or M writer targets one of its sources. W needs no
//               stall because the regfile writes on the falling edge.
//
// Handshake: there is none. Every output is combinational from the shadow
// registers and the current decode/execute inputs and is valid in the same
// cycle; the shadow registers advance on every rising edge of clk.

module hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             Rs1D,
  input  logic [4:0]             Rs2D,
  input  logic [4:0]             RdD,
  input  logic                   RegWriteD,
  input  logic [1:0]             ResultSrcD,
  input  logic                   PCSrcE,
  output logic [1:0]             ForwardAE,
  output logic [1:0]             ForwardBE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic [STALL_CNT_W-1:0] StallCnt
);

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUM    = 2'b10;
  localparam logic [1:0] RES_LOAD    = 2'b01;

  // ---------------------------------------------------------------------------
  // Shadow pipeline state
  // ---------------------------------------------------------------------------
  logic [4:0]             rd_e_q,       rd_e_d;
  logic                   regwrite_e_q, regwrite_e_d;
  logic [4:0]             rd_m_q;
  logic                   regwrite_m_q;
  logic [4:0]             rd_w_q;
  logic                   regwrite_w_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

`ifdef HAZARD_FORWARD_EN
  // Source registers and load flag in E are only consulted when forwarding.
  logic [4:0] rs1_e_q,  rs1_e_d;
  logic [4:0] rs2_e_q,  rs2_e_d;
  logic       load_e_q, load_e_d;
`endif

  // Writer qualification: x0 is never a real destination.
  logic wr_m;
  logic wr_w;
  logic stall;

  assign wr_m = regwrite_m_q & (rd_m_q != 5'd0);
  assign wr_w = regwrite_w_q & (rd_w_q != 5'd0);

`ifdef HAZARD_FORWARD_EN
  // ---------------------------------------------------------------------------
  // Forwarding: the youngest writer (M) wins over the older one (W).
  // ---------------------------------------------------------------------------
  // Operand A/B forwarding selects from the shadow M and W writers.
  always_comb begin
    ForwardAE = FWD_REGFILE;
    ForwardBE = FWD_REGFILE;
    if (wr_m && (rd_m_q == rs1_e_q)) begin
      ForwardAE = FWD_ALUM;
    end else if (wr_w && (rd_w_q == rs1_e_q)) begin
      ForwardAE = FWD_RESULTW;
    end
    if (wr_m && (rd_m_q == rs2_e_q)) begin
      ForwardBE = FWD_ALUM;
    end else if (wr_w && (rd_w_q == rs2_e_q)) begin
      ForwardBE = FWD_RESULTW;
    end
  end

  // A load's data only exists after M, so a dependent decode instruction
  // has to wait one cycle; everything else is covered by forwarding.
  assign stall = load_e_q & (rd_e_q != 5'd0) &
                 ((rd_e_q == Rs1D) | (rd_e_q == Rs2D));
`else
  logic wr_e;
  logic unused_fwd_fields;

  assign ForwardAE = FWD_REGFILE;
  assign ForwardBE = FWD_REGFILE;

  assign wr_e = regwrite_e_q & (rd_e_q != 5'd0);

  // Without forwarding a reader waits until its producer reaches W; the
  // regfile's falling-edge write makes the W value visible in decode.
  assign stall = (wr_e & ((rd_e_q == Rs1D) | (rd_e_q == Rs2D))) |
                 (wr_m & ((rd_m_q == Rs1D) | (rd_m_q == Rs2D)));

  // The result select only matters for load detection when forwarding.
  assign unused_fwd_fields = ^ResultSrcD;
`endif

  // ---------------------------------------------------------------------------
  // Control outputs. A taken branch discards the decode instruction, so any
  // stall it would have caused is pointless and is suppressed.
  // ---------------------------------------------------------------------------
  assign StallD   = stall & ~PCSrcE;
  assign StallF   = StallD;
  assign FlushD   = PCSrcE;
  assign FlushE   = stall | PCSrcE;
  assign StallCnt = stall_cnt_q;

  // Next-state of the E shadow stage: decode fields, or a bubble on flush.
  always_comb begin
    rd_e_d       = RdD;
    regwrite_e_d = RegWriteD;
`ifdef HAZARD_FORWARD_EN
    rs1_e_d      = Rs1D;
    rs2_e_d      = Rs2D;
    load_e_d     = (ResultSrcD == RES_LOAD);
`endif
    if (FlushE) begin
      rd_e_d       = 5'd0;
      regwrite_e_d = 1'b0;
`ifdef HAZARD_FORWARD_EN
      rs1_e_d      = 5'd0;
      rs2_e_d      = 5'd0;
      load_e_d     = 1'b0;
`endif
    end
  end

  // Next-state of the stall counter: count stalled cycles, hold at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallD && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Shadow pipeline and counter registers; E/M/W never stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_e_q       <= 5'd0;
      regwrite_e_q <= 1'b0;
      rd_m_q       <= 5'd0;
      regwrite_m_q <= 1'b0;
      rd_w_q       <= 5'd0;
      regwrite_w_q <= 1'b0;
      stall_cnt_q  <= '0;
`ifdef HAZARD_FORWARD_EN
      rs1_e_q      <= 5'd0;
      rs2_e_q      <= 5'd0;
      load_e_q     <= 1'b0;
`endif
    end else begin
      rd_e_q       <= rd_e_d;
      regwrite_e_q <= regwrite_e_d;
      rd_m_q       <= rd_e_q;
      regwrite_m_q <= regwrite_e_q;
      rd_w_q       <= rd_m_q;
      regwrite_w_q <= regwrite_m_q;
      stall_cnt_q  <= stall_cnt_d;
`ifdef HAZARD_FORWARD_EN
      rs1_e_q      <= rs1_e_d;
      rs2_e_q      <= rs2_e_d;
      load_e_q     <= load_e_d;
`endif
    end
  end

endmodule
